counter_uart_tx: RTL and testbench



---
 rtl/counter_uart_tx.sv | 123 ++++++++++++
 tb/tb_counter_uart_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/counter_uart_tx.sv
// UART 8N1 transmitter that frames each new stable value of the free-running counter byte.
// Values that change while a frame is on the line are dropped; only the newest stable one follows.
module counter_uart_tx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    d1_reg, d2_reg;
    logic [7:0]    last_sent_reg, last_sent_next;
    logic [7:0]    shreg_reg, shreg_next, shreg_shr;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic          launch, bit_end;

    // A two-stage match means the value held for at least two edges; one-cycle glitches never launch.
    assign launch  = (d1_reg == d2_reg) && (d2_reg != last_sent_reg);
    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_shr
            assign shreg_shr[gi] = shreg_reg[gi+1];
        end
    endgenerate
    assign shreg_shr[7] = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            d1_reg        <= '0;
            d2_reg        <= '0;
            last_sent_reg <= '0;
            shreg_reg     <= '0;
            bit_idx_reg   <= '0;
            baud_cnt_reg  <= '0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            d1_reg        <= data;
            d2_reg        <= d1_reg;
            last_sent_reg <= last_sent_next;
            shreg_reg     <= shreg_next;
            bit_idx_reg   <= bit_idx_next;
            baud_cnt_reg  <= baud_cnt_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && bit_idx_reg == 3'd7) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next        = tx_reg;
        busy_next      = busy_reg;
        shreg_next     = shreg_reg;
        last_sent_next = last_sent_reg;
        bit_idx_next   = bit_idx_reg;
        baud_cnt_next  = (state_reg == IDLE || bit_end) ? '0 : baud_cnt_reg + CW'(1);
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    shreg_next     = d2_reg;
                    last_sent_next = d2_reg;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next      = shreg_reg[0];
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg != 3'd7) begin
                        shreg_next   = shreg_shr;
                        tx_next      = shreg_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end else begin
                        tx_next = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    busy_next = 1'b0;
                    tx_next   = 1'b1;
                end
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_counter_uart_tx.sv
// Directed bench for counter_uart_tx at BAUD_DIV=4: stimulus queues expected frames,
// a monitor decodes every frame seen on tx and checks it against the queue head.
module tb_counter_uart_tx;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [7:0] b;
        int         start;
        bit         aborted;
    } exp_t;
    exp_t exp_q[$];

    counter_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic set_data(input logic [7:0] v);
        @(negedge clk);
        #1 data = v;
    endtask

    task automatic push(input logic [7:0] b, input int start, input bit aborted);
        exp_t e;
        e.b = b;
        e.start = start;
        e.aborted = aborted;
        exp_q.push_back(e);
    endtask

    task automatic idle_window(input string name, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    // Monitor: samples at negedges, so every DUT output is read half a cycle after it changes.
    initial begin
        logic       samp_tx [0:40];
        logic       samp_busy [0:40];
        exp_t       e;
        int         start_cyc;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && (tx === 1'b0 || busy === 1'b1)) begin
                start_cyc = cyc;
                aborted = 1'b0;
                if (exp_q.size() == 0) begin
                    e.b = 8'hxx;
                    e.start = -1;
                    e.aborted = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                end
                check("frame_start_cycle", start_cyc, e.start);
                for (int j = 0; j < 41; j++) begin
                    if (j > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        check("abort_line_idle", {tx, busy}, 2'b10);
                        break;
                    end
                    samp_tx[j] = tx;
                    samp_busy[j] = busy;
                end
                check("frame_aborted", aborted, e.aborted);
                if (!aborted) begin
                    int         mism = 0;
                    int         busy_bad = 0;
                    logic [7:0] dec;
                    for (int i = 0; i < 10; i++) begin
                        logic want_bit;
                        want_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : e.b[i-1];
                        for (int k = 0; k < BD; k++) begin
                            if (samp_tx[BD*i+k] !== want_bit) mism++;
                            if (samp_busy[BD*i+k] !== 1'b1) busy_bad++;
                        end
                    end
                    for (int i = 0; i < 8; i++) dec[i] = samp_tx[BD*(i+1)+2];
                    check("frame_data_byte", dec, e.b);
                    check("frame_tx_bit_samples", mism, 0);
                    check("frame_busy_high", busy_bad, 0);
                    check("frame_busy_fall", samp_busy[40], 1'b0);
                    $display("frame: byte=%02h start_cycle=%0d", dec, start_cyc);
                end else begin
                    $display("frame: abandoned by reset, start_cycle=%0d", start_cyc);
                end
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1;
        data = 8'h00;

        // Reset state, then a long quiet stretch with the counter parked at zero.
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        #1 rst = 1'b0;
        idle_window("post_reset_idle", 100);

        // One-cycle glitch never becomes stable.
        set_data(8'hFF);
        set_data(8'h00);
        idle_window("glitch_idle", 60);

        // Single 0x55 frame.
        set_data(8'h55);
        push(8'h55, cyc + 3, 1'b0);
        repeat (60) @(negedge clk);

        // Coalescing: 0x02 arrives mid-frame and is overwritten by 0x03 before the frame ends.
        set_data(8'h01);
        c0 = cyc;
        push(8'h01, c0 + 3, 1'b0);
        push(8'h03, c0 + 3 + 10*BD + 1, 1'b0);
        repeat (9) @(negedge clk);
        set_data(8'h02);
        repeat (9) @(negedge clk);
        set_data(8'h03);
        repeat (70) @(negedge clk);

        // Wrap-around 0xFF -> 0x00.
        set_data(8'hFF);
        c0 = cyc;
        push(8'hFF, c0 + 3, 1'b0);
        repeat (49) @(negedge clk);
        set_data(8'h00);
        push(8'h00, cyc + 3, 1'b0);
        repeat (50) @(negedge clk);

        // Reset during data bit 3 of 0xA5, then the same value is framed again.
        set_data(8'hA5);
        c0 = cyc;
        push(8'hA5, c0 + 3, 1'b1);
        repeat (19) @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        push(8'hA5, cyc + 3, 1'b0);
        repeat (60) @(negedge clk);

        check("pending_frames", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
